// File: rtl/alu.sv
// 8-bit, 16-op combinational ALU with a registered flag latch; ALU_TRISTATE_EN floats result when oe=1.
// Latency: result/flags zero-cycle combinational; flags_q updates one clk edge after flags_we.
// Backpressure: none, operands are consumed every cycle and the flag latch is write-enabled only.
module alu (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [3:0] op,
   input  logic       invert,
   input  logic       carry_in,
   input  logic       oe,
   input  logic       flags_we,
   output logic [7:0] result,
   output logic [3:0] flags,
   output logic [3:0] flags_q
);

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_ADC = 4'd2,  OP_SBB = 4'd3,
      OP_INC = 4'd4,  OP_DEC = 4'd5,  OP_SHL = 4'd6,  OP_NEG = 4'd7,
      OP_MOV = 4'd8,  OP_NOT = 4'd9,  OP_EXP = 4'd10, OP_AND = 4'd11,
      OP_OR  = 4'd12, OP_XOR = 4'd13, OP_SHR = 4'd14, OP_SAR = 4'd15
   } op_e;

   op_e        op_sel;
   logic [7:0] x, y, r;
   logic [8:0] sum9;
   logic       c, v;

   assign op_sel = op_e'(op);
   assign x      = invert ? b : a;
   assign y      = invert ? a : b;

   always_comb begin
      r    = 8'h00;
      c    = 1'b0;
      v    = 1'b0;
      sum9 = 9'h000;
      case (op_sel)
         OP_ADD: begin
            sum9 = {1'b0, x} + {1'b0, y};
            r    = sum9[7:0];
            c    = sum9[8];
            v    = (x[7] == y[7]) && (r[7] != x[7]);
         end
         OP_SUB: begin
            // bit 8 of the 9-bit difference is the borrow
            sum9 = {1'b0, x} - {1'b0, y};
            r    = sum9[7:0];
            c    = sum9[8];
            v    = (x[7] != y[7]) && (r[7] != x[7]);
         end
         OP_ADC: begin
            sum9 = {1'b0, x} + {1'b0, y} + {8'h00, carry_in};
            r    = sum9[7:0];
            c    = sum9[8];
            v    = (x[7] == y[7]) && (r[7] != x[7]);
         end
         OP_SBB: begin
            sum9 = {1'b0, x} - {1'b0, y} - {8'h00, carry_in};
            r    = sum9[7:0];
            c    = sum9[8];
            v    = (x[7] != y[7]) && (r[7] != x[7]);
         end
         OP_INC: begin
            r = x + 8'h01;
            c = (x == 8'hFF);
            v = !x[7] && r[7];
         end
         OP_DEC: begin
            r = x - 8'h01;
            c = (x == 8'h00);
            v = x[7] && !r[7];
         end
         OP_SHL: begin
            r = {x[6:0], 1'b0};
            c = x[7];
            v = x[7] ^ r[7];
         end
         OP_NEG: begin
            r = 8'h00 - x;
            c = (x != 8'h00);
            v = (x == 8'h80);
         end
         OP_MOV: r = x;
         OP_NOT: r = ~x;
         OP_EXP: r = carry_in ? 8'hFF : 8'h00;
         OP_AND: r = x & y;
         OP_OR:  r = x | y;
         OP_XOR: r = x ^ y;
         OP_SHR: begin
            r = {1'b0, x[7:1]};
            c = x[0];
         end
         OP_SAR: begin
            r = {x[7], x[7:1]};
            c = x[0];
         end
      endcase
   end

   assign flags = {v, r[7], c, (r == 8'h00)};

`ifdef ALU_TRISTATE_EN
   assign result = oe ? 8'hzz : r;
`else
   assign result = oe ? 8'h00 : r;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= 4'h0;
      end else if (flags_we) begin
         flags_q <= flags;
      end
   end

endmodule

// File: tb/tb_alu.sv
// Directed and corner-value checks of the alu result/flags and the flag register.
module tb_alu;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] a, b;
   logic [3:0] op;
   logic       invert, carry_in, oe, flags_we;
   logic [7:0] result;
   logic [3:0] flags, flags_q;

   int n_checks = 0;
   int n_fails  = 0;

   alu dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .invert(invert),
      .carry_in(carry_in), .oe(oe), .flags_we(flags_we),
      .result(result), .flags(flags), .flags_q(flags_q)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] o, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input logic inv);
      op = o; a = av; b = bv; carry_in = ci; invert = inv;
      #1;
   endtask

   // Reference built from integer arithmetic and signed range tests.
   function automatic logic [11:0] model(input logic [3:0] o, input logic [7:0] av,
                                         input logic [7:0] bv, input logic ci, input logic inv);
      int x, y, sx, sy, s, r, cc;
      logic c, v;
      x  = inv ? int'(bv) : int'(av);
      y  = inv ? int'(av) : int'(bv);
      sx = (x >= 128) ? x - 256 : x;
      sy = (y >= 128) ? y - 256 : y;
      cc = ci ? 1 : 0;
      c = 1'b0; v = 1'b0; r = 0;
      case (o)
         4'd0:  begin s = x + y;       c = (s > 255); v = (sx + sy > 127) || (sx + sy < -128); r = s % 256; end
         4'd1:  begin s = x - y;       c = (s < 0);   v = (sx - sy > 127) || (sx - sy < -128); r = (s + 256) % 256; end
         4'd2:  begin s = x + y + cc;  c = (s > 255); v = (sx + sy + cc > 127) || (sx + sy + cc < -128); r = s % 256; end
         4'd3:  begin s = x - y - cc;  c = (s < 0);   v = (sx - sy - cc > 127) || (sx - sy - cc < -128); r = (s + 512) % 256; end
         4'd4:  begin r = (x + 1) % 256; c = (x == 255); v = (sx + 1 > 127); end
         4'd5:  begin r = (x + 255) % 256; c = (x == 0); v = (sx - 1 < -128); end
         4'd6:  begin r = (x * 2) % 256; c = (x >= 128); v = (sx * 2 > 127) || (sx * 2 < -128); end
         4'd7:  begin r = (256 - x) % 256; c = (x != 0); v = (-sx > 127); end
         4'd8:  r = x;
         4'd9:  r = 255 - x;
         4'd10: r = ci ? 255 : 0;
         4'd11: r = x & y;
         4'd12: r = x | y;
         4'd13: r = x ^ y;
         4'd14: begin r = x / 2; c = (x % 2 == 1); end
         default: begin r = (sx >>> 1) & 255; c = (x % 2 == 1); end
      endcase
      return {r[7:0], v, (r >= 128), c, (r == 0)};
   endfunction

   logic [7:0] vals [10] = '{8'h00, 8'h01, 8'h10, 8'h55, 8'h7F, 8'h80, 8'h81, 8'hAA, 8'hFE, 8'hFF};

   initial begin
      rst_n = 1'b0; a = 8'h00; b = 8'h00; op = 4'd0; invert = 1'b0;
      carry_in = 1'b0; oe = 1'b0; flags_we = 1'b0;
      #1;
      check("reset_flags_q", {8'h00, flags_q}, 12'h000);

      // ADD is independent of carry_in, and commutative under invert
      for (int k = 0; k < 4; k++) begin
         drive(4'd0, 8'h7F, 8'h02, k[0], k[1]); check("add_7f_02", {result, flags}, 12'h81C);
         drive(4'd0, 8'hFF, 8'h02, k[0], k[1]); check("add_ff_02", {result, flags}, 12'h012);
         drive(4'd0, 8'hFF, 8'hFF, k[0], k[1]); check("add_ff_ff", {result, flags}, 12'hFE6);
         drive(4'd0, 8'h00, 8'h00, k[0], k[1]); check("add_00_00", {result, flags}, 12'h001);
      end

      drive(4'd1, 8'h05, 8'h0A, 1'b0, 1'b0); check("sub_05_0a", {result, flags}, 12'hFB6);
      drive(4'd1, 8'h70, 8'hEF, 1'b0, 1'b0); check("sub_70_ef", {result, flags}, 12'h81E);
      drive(4'd1, 8'h10, 8'h01, 1'b1, 1'b0); check("sub_10_01", {result, flags}, 12'h0F0);

      drive(4'd2, 8'h7F, 8'h00, 1'b1, 1'b0); check("adc_7f_00_c1", {result, flags}, 12'h80C);
      drive(4'd3, 8'h00, 8'h00, 1'b1, 1'b0); check("sbb_00_00_c1", {result, flags}, 12'hFF6);
      drive(4'd10, 8'h12, 8'h34, 1'b1, 1'b0); check("exp_c1", {result, flags}, 12'hFF4);
      drive(4'd10, 8'h12, 8'h34, 1'b0, 1'b0); check("exp_c0", {result, flags}, 12'h001);

      drive(4'd1,  8'h01, 8'h10, 1'b0, 1'b1); check("inv_sub", {result, flags}, 12'h0F0);
      drive(4'd14, 8'h01, 8'h10, 1'b0, 1'b1); check("inv_shr", {result, flags}, 12'h080);
      drive(4'd15, 8'h01, 8'h81, 1'b0, 1'b1); check("inv_sar", {result, flags}, 12'hC06);

      // oe gates only the result bus
      oe = 1'b1;
      drive(4'd0, 8'h7F, 8'h02, 1'b0, 1'b0);
`ifdef ALU_TRISTATE_EN
      check("oe_result", {result, 4'h0}, {8'hzz, 4'h0});
`else
      check("oe_result", {result, 4'h0}, 12'h000);
`endif
      check("oe_flags", {8'h00, flags}, 12'h00C);
      oe = 1'b0;

      for (int o = 0; o < 16; o++)
         for (int ia = 0; ia < 10; ia++)
            for (int ib = 0; ib < 10; ib++)
               for (int m = 0; m < 4; m++) begin
                  drive(4'(o), vals[ia], vals[ib], m[0], m[1]);
                  check($sformatf("sweep_op%0d_%h_%h_m%0d", o, vals[ia], vals[ib], m),
                        {result, flags}, model(4'(o), vals[ia], vals[ib], m[0], m[1]));
               end

      // Flag register
      @(negedge clk);
      check("flags_q_in_reset", {8'h00, flags_q}, 12'h000);
      rst_n = 1'b1;
      op = 4'd0; a = 8'hFF; b = 8'h02; invert = 1'b0; carry_in = 1'b0; flags_we = 1'b1;
      @(posedge clk); #1;
      check("flags_q_capture", {8'h00, flags_q}, 12'h002);
      flags_we = 1'b0;
      a = 8'h7F;
      @(posedge clk); #1;
      op = 4'd1; a = 8'h05; b = 8'h0A;
      @(posedge clk); #1;
      check("flags_q_hold", {8'h00, flags_q}, 12'h002);
      flags_we = 1'b1;
      @(posedge clk); #1;
      check("flags_q_capture2", {8'h00, flags_q}, 12'h006);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("flags_q_async_reset", {8'h00, flags_q}, 12'h000);
      @(posedge clk); #1;
      check("flags_q_reset_wins", {8'h00, flags_q}, 12'h000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("flags_q_after_release", {8'h00, flags_q}, 12'h006);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
